dma_write_engine: RTL and testbench

- Bus-master side of the DMA protocol; the CPU hazard/stall controller is the other end.
- On a CPU command, requests the bus (BR), waits for grant (BG), then writes a fixed-length block of device words into data memory.
- Publishes a word counter whose terminal value (TOTAL_WORDS-1) tells the CPU the bus is about to be released.
- Signals completion to the CPU with a one-cycle interrupt.

---
 rtl/dma_write_engine_pkg.sv | 26 ++
 rtl/dma_addr_counter.sv | 48 ++++
 rtl/dma_write_engine.sv | 111 +++++++++++
 tb/tb_dma_write_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_write_engine_pkg.sv
// Shared DMA definitions: state encodings, block/burst defaults and the terminal
// counter value that the CPU stall logic also watches to anticipate bus release.
package dma_write_engine_pkg;

  // Stand-in for the WORD_SIZE constant of the processor opcode/constants header.
  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_TOTAL_WORDS = 12;
  localparam int DMA_BURST_LEN   = 4;
  localparam int DMA_CNT_W       = 4;

  typedef logic [2:0] dma_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  function automatic logic [DMA_CNT_W-1:0] dma_terminal_count(input int total_words);
    return DMA_CNT_W'(total_words - 1);
  endfunction

  localparam logic [DMA_CNT_W-1:0] DMA_TERMINAL_COUNT = dma_terminal_count(DMA_TOTAL_WORDS);

endpackage

// File: rtl/dma_addr_counter.sv
// Word counter, base-address register and address adder for the DMA write engine,
// plus terminal-word and burst-boundary detection on the current count.
module dma_addr_counter
  import dma_write_engine_pkg::*;
#(
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int TOTAL_WORDS = DMA_TOTAL_WORDS,
  parameter int BURST_LEN   = DMA_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] start_base,
  input  logic                 step,
  output logic [DMA_CNT_W-1:0] count,
  output logic [WORD_SIZE-1:0] word_addr,
  output logic                 last,
  output logic                 burst_end
);

  localparam logic [DMA_CNT_W-1:0] TERMINAL  = dma_terminal_count(TOTAL_WORDS);
  localparam logic [DMA_CNT_W:0]   BURST_MOD = (DMA_CNT_W+1)'(BURST_LEN);
  localparam logic [DMA_CNT_W:0]   BURST_TOP = (DMA_CNT_W+1)'(BURST_LEN - 1);

  logic [WORD_SIZE-1:0] base;
  logic [DMA_CNT_W:0]   count_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base  <= '0;
      count <= '0;
    end else if (start) begin
      base  <= start_base;
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
    end
  end

  // Address wraps modulo 2^WORD_SIZE by construction of the adder width.
  assign word_addr = base + {{(WORD_SIZE-DMA_CNT_W){1'b0}}, count};
  assign last      = (count == TERMINAL);

  // Extra bit keeps the modulus non-zero when a burst spans all 16 words.
  assign count_ext = {1'b0, count};
  assign burst_end = ((count_ext % BURST_MOD) == BURST_TOP);

endmodule

// File: rtl/dma_write_engine.sv
// Bus-master DMA write engine: BR/BG handshake, then a fixed-length block of device
// words written to memory. Optional macro DMA_CYCLE_STEAL_EN releases the bus between bursts.
module dma_write_engine
  import dma_write_engine_pkg::*;
#(
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int TOTAL_WORDS = DMA_TOTAL_WORDS,
  parameter int BURST_LEN   = DMA_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic                 BG,
  output logic                 BR,
  output logic [3:0]           dma_counter,
  input  logic [WORD_SIZE-1:0] dev_data,
  input  logic                 dev_valid,
  output logic                 dev_pop,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_write,
  input  logic                 mem_ack,
  output logic                 dma_end,
  output logic                 busy
);

  dma_state_t           state;
  logic                 start;
  logic                 capture;
  logic                 acked;
  logic                 step;
  logic [3:0]           count;
  logic [WORD_SIZE-1:0] word_addr;
  logic                 last;
  logic                 burst_end;

  assign start   = (state == ST_IDLE) && cmd_valid;
  assign capture = (state == ST_LOAD) && BG && dev_valid;
  // An ack only counts while the grant is held at the same edge.
  assign acked   = (state == ST_WRITE) && BG && mem_ack;
  assign step    = acked && !last;

  dma_addr_counter #(
    .WORD_SIZE  (WORD_SIZE),
    .TOTAL_WORDS(TOTAL_WORDS),
    .BURST_LEN  (BURST_LEN)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_base(cmd_addr),
    .step      (step),
    .count     (count),
    .word_addr (word_addr),
    .last      (last),
    .burst_end (burst_end)
  );

`ifndef DMA_CYCLE_STEAL_EN
  logic unused_burst_end;
  assign unused_burst_end = burst_end;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) state <= ST_REQ;
        end
        ST_REQ: begin
          if (BG) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (capture) begin
            mem_data <= dev_data;
            mem_addr <= word_addr;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (acked) begin
            if (last) state <= ST_DONE;
`ifdef DMA_CYCLE_STEAL_EN
            else if (burst_end) state <= ST_RELEASE;
`endif
            else state <= ST_LOAD;
          end
        end
        ST_DONE: state <= ST_IDLE;
`ifdef DMA_CYCLE_STEAL_EN
        ST_RELEASE: state <= ST_REQ;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus-facing strobes decode straight from state so reset clears them at once.
  assign BR          = (state == ST_REQ) || (state == ST_LOAD) || (state == ST_WRITE);
  assign busy        = (state != ST_IDLE);
  assign mem_write   = (state == ST_WRITE) && BG;
  assign dev_pop     = capture;
  assign dma_end     = (state == ST_DONE);
  assign dma_counter = count;

endmodule

// File: tb/tb_dma_write_engine.sv
// Randomized scoreboard bench for dma_write_engine: expected writes are queued per
// command and a separate monitor matches every memory write the engine presents.
module tb_dma_write_engine;

  localparam int W  = 16;
  localparam int TW = 12;
  localparam int BL = 4;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic [W-1:0] cmd_addr;
  logic         BG;
  logic         BR;
  logic [3:0]   dma_counter;
  logic [W-1:0] dev_data;
  logic         dev_valid;
  logic         dev_pop;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_data;
  logic         mem_write;
  logic         mem_ack;
  logic         dma_end;
  logic         busy;

  dma_write_engine dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .BG         (BG),
    .BR         (BR),
    .dma_counter(dma_counter),
    .dev_data   (dev_data),
    .dev_valid  (dev_valid),
    .dev_pop    (dev_pop),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .mem_ack    (mem_ack),
    .dma_end    (dma_end),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           idx;
  } wr_t;

  wr_t          exp_q[$];
  logic [W-1:0] dev_words[TW];
  int vectors = 0;
  int miscompares = 0;
  int end_cnt = 0;
  int end_base;
  int dev_idx, pops;
  // Scenario knobs
  int bg_delay, drop_word, drop_len, drop_left, gap_word, gap_len, gap_left;
  int ack_delay, ack_wait, br_cnt;
  bit rnd_mode, drop_done, gap_done, inject_busy, inject_done, cmd_req;
  logic [W-1:0] cmd_base;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    bg_delay = 0; drop_word = -1; drop_len = 0; drop_left = 0;
    gap_word = -1; gap_len = 0; gap_left = 0;
    ack_delay = 0; ack_wait = 0; rnd_mode = 0; inject_busy = 0;
  endtask

  // One clock of CPU / device / memory behaviour; inputs change on the falling edge.
  task automatic cycle();
    @(negedge clk);
    if (!BR) begin
      br_cnt = 0;
      BG = 1'b0;
    end else begin
      br_cnt++;
      if (drop_left > 0) begin
        drop_left--;
        BG = 1'b0;
      end else if (mem_write && int'(dma_counter) == drop_word && !drop_done) begin
        drop_done = 1;
        drop_left = drop_len - 1;
        BG = 1'b0;
      end else if (rnd_mode && BG && $urandom_range(0, 9) == 0) begin
        drop_left = $urandom_range(0, 3);
        BG = 1'b0;
      end else begin
        BG = (br_cnt > bg_delay);
      end
    end
    if (gap_left > 0) begin
      gap_left--;
      dev_valid = 1'b0;
    end else if (dev_idx == gap_word && !gap_done) begin
      gap_done = 1;
      gap_left = gap_len - 1;
      dev_valid = 1'b0;
    end else begin
      dev_valid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    dev_data = (dev_idx < TW) ? dev_words[dev_idx] : W'($urandom);
    cmd_valid = cmd_req;
    cmd_addr  = cmd_req ? cmd_base : W'($urandom);
    if (inject_busy && !inject_done && mem_write) begin
      inject_done = 1;
      cmd_valid = 1'b1;
      cmd_addr  = 16'hDEAD;
    end
    #1;
    if (mem_write) begin
      if (ack_wait >= ack_delay) begin
        mem_ack = 1'b1;
        ack_wait = 0;
        if (rnd_mode) ack_delay = $urandom_range(0, 3);
      end else begin
        mem_ack = 1'b0;
        ack_wait++;
      end
    end else begin
      // Stray acks without a grant must be ignored by the engine.
      mem_ack = BG ? 1'b0 : 1'($urandom_range(0, 1));
    end
    if (dev_pop) begin
      if (!dev_valid || dev_idx >= TW) begin
        vectors++; miscompares++;
        $display("FAIL dev_pop: pop %0d with dev_valid=%0b, at most %0d valid pops allowed", dev_idx, dev_valid, TW);
      end
      pops++;
      dev_idx++;
    end
  endtask

  task automatic start_cmd(input logic [W-1:0] base);
    chk("busy before cmd", int'(busy), 0);
    for (int i = 0; i < TW; i++) begin
      wr_t e;
      dev_words[i] = W'($urandom);
      e.addr = base + W'(i);
      e.data = dev_words[i];
      e.idx  = i;
      exp_q.push_back(e);
    end
    dev_idx = 0; pops = 0; drop_done = 0; gap_done = 0; inject_done = 0;
    end_base = end_cnt;
    cmd_base = base;
    cmd_req = 1;
    cycle();
    cmd_req = 0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000 && end_cnt == end_base; n++) cycle();
    repeat (3) cycle();
    chk("dma_end count", end_cnt - end_base, 1);
    chk("dev_pop total", pops, TW);
    chk("writes outstanding", exp_q.size(), 0);
    chk("counter hold", int'(dma_counter), TW - 1);
    chk("busy after done", int'(busy), 0);
  endtask

  task automatic run_cmd(input logic [W-1:0] base);
    start_cmd(base);
    wait_done();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " BR"}, int'(BR), 0);
    chk({tag, " mem_write"}, int'(mem_write), 0);
    chk({tag, " dev_pop"}, int'(dev_pop), 0);
    chk({tag, " dma_end"}, int'(dma_end), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " dma_counter"}, int'(dma_counter), 0);
    chk({tag, " mem_addr"}, int'(mem_addr), 0);
    chk({tag, " mem_data"}, int'(mem_data), 0);
  endtask

  // Monitor: compares every presented write against the head of the scoreboard.
  initial begin
    bit acc_prev, acc_now, prev_br, br_back;
    int last_idx;
    acc_prev = 0; prev_br = 0; br_back = 0; last_idx = -1;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        acc_prev = 0; prev_br = 0; br_back = 0; last_idx = -1;
        continue;
      end
      acc_now = 0;
      if (busy && !BG) chk("mem_write without grant", int'(mem_write), 0);
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_data);
        end else begin
          chk("mem_addr", int'(mem_addr), int'(exp_q[0].addr));
          chk("mem_data", int'(mem_data), int'(exp_q[0].data));
          chk("dma_counter in write", int'(dma_counter), exp_q[0].idx);
          if (mem_ack && BG) begin
            last_idx = exp_q[0].idx;
            void'(exp_q.pop_front());
            acc_now = 1;
          end
        end
      end
      if (dma_end) begin
        chk("BR at dma_end", int'(BR), 0);
        chk("dma_end after last ack", acc_prev ? last_idx : -1, TW - 1);
        chk("counter at dma_end", int'(dma_counter), TW - 1);
        end_cnt++;
      end
      if (br_back) chk("BR after release", int'(BR), 1);
      br_back = 0;
`ifdef DMA_CYCLE_STEAL_EN
      if (acc_prev && (last_idx % BL) == BL - 1 && last_idx != TW - 1) begin
        chk("BR released after burst", int'(BR), 0);
        chk("counter across release", int'(dma_counter), last_idx + 1);
        br_back = 1;
      end else if (prev_br && !BR && !dma_end) begin
        vectors++; miscompares++;
        $display("FAIL BR drop: dropped at counter %0d, allowed only after a burst or at dma_end", dma_counter);
      end
`else
      if (prev_br && !BR && !dma_end) begin
        vectors++; miscompares++;
        $display("FAIL BR drop: dropped at counter %0d, required high until dma_end", dma_counter);
      end
`endif
      prev_br  = BR;
      acc_prev = acc_now;
    end
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; BG = 1'b0; dev_data = '0;
    dev_valid = 1'b0; mem_ack = 1'b0; cmd_req = 0; cmd_base = '0; br_cnt = 0;
    dev_idx = 0; pops = 0; end_base = 0;
    set_defaults();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic transfer, grant three cycles after request
    set_defaults(); bg_delay = 3;
    run_cmd(16'h00C0);

    // Grant withdrawn for five cycles while word 6 is being written
    set_defaults(); bg_delay = 3; drop_word = 6; drop_len = 5;
    run_cmd(16'h00C0);

    // Asynchronous reset while word 4 is in flight
    set_defaults(); bg_delay = 1;
    start_cmd(16'h00C0);
    for (int n = 0; n < 3000 && !(int'(dma_counter) == 4 && mem_write); n++) cycle();
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_zero("async reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    br_cnt = 0;
    run_cmd(16'h0200);

    // Command pulsed while busy must be ignored
    set_defaults(); inject_busy = 1;
    run_cmd(16'h00C0);

    // Slow memory and device gap before word 9
    set_defaults(); ack_delay = 3; gap_word = 9; gap_len = 2;
    run_cmd(16'h0340);

    // Address wrap at the top of the space
    set_defaults(); bg_delay = 2;
    run_cmd(16'hFFF8);

    // Randomized timing on grant, device and memory
    for (int k = 0; k < 6; k++) begin
      set_defaults();
      rnd_mode = 1;
      bg_delay = $urandom_range(0, 4);
      ack_delay = $urandom_range(0, 3);
      run_cmd(W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
